// File: rtl/shreg_pkg.sv
// Shared types and helpers for the universal shift register: op-select
// encoding, burst FSM states and mode classification.
package shreg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_SHL   = 3'b001,
      MODE_SHR   = 3'b010,
      MODE_ROL   = 3'b011,
      MODE_ROR   = 3'b100,
      MODE_PLOAD = 3'b101,
      MODE_ASR   = 3'b110,
      MODE_RSVD  = 3'b111
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_shift_mode(mode_e m);
      return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR};
   endfunction

   // Serial-out direction a mode selects: 1 = rightward (so taken from bit 0).
   function automatic logic shift_dir(mode_e m);
      return m inside {MODE_SHR, MODE_ROR, MODE_ASR};
   endfunction

endpackage

// File: rtl/shreg_burst_ctrl.sv
// Burst controller: IDLE/RUN FSM, burst counter, latched mode, busy/done.
// Decides each cycle whether the datapath executes an op and which one.
module shreg_burst_ctrl
   import shreg_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] len,
   output logic             op_en,
   output logic [2:0]       op_sel,
   output logic             dir_ld,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [2:0]       mode_q;
   logic             done_q;
   logic             start_ok;

   always_comb begin
      op_en    = 1'b0;
      op_sel   = mode;
      dir_ld   = 1'b0;
      start_ok = (state_q == ST_IDLE) && start && (len != '0) &&
                 is_shift_mode(mode_e'(mode));
      if (state_q == ST_RUN) begin
         op_en  = 1'b1;
         op_sel = mode_q;
      end else if (start_ok) begin
         dir_ld = 1'b1;   // start edge only arms the burst, no shift
      end else if (en) begin
         op_en  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         mode_q  <= 3'b000;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_q <= ST_RUN;
                  count_q <= len;
                  mode_q  <= mode;
               end
            end
            ST_RUN: begin
               count_q <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal shift register with burst engine.
// Optional parity output enabled by defining SHREG_PARITY_EN.
module univ_shift_reg
   import shreg_pkg::*;
#(
   parameter  int N     = 4,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             si,
   input  logic [N-1:0]     pdata,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic [N-1:0]     q,
   output logic             so,
   output logic             busy,
   output logic             done
`ifdef SHREG_PARITY_EN
   ,
   output logic             par
`endif
);

   logic [N-1:0] q_q, q_d;
   logic         dir_q, dir_d;
   logic         op_en;
   logic [2:0]   op_sel;
   logic         dir_ld;

   shreg_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
      .clk    (clk),
      .clear  (clear),
      .en     (en),
      .start  (start),
      .mode   (mode),
      .len    (len),
      .op_en  (op_en),
      .op_sel (op_sel),
      .dir_ld (dir_ld),
      .busy   (busy),
      .done   (done)
   );

   always_comb begin
      q_d   = q_q;
      dir_d = dir_q;
      if (dir_ld) begin
         dir_d = shift_dir(mode_e'(mode));
      end
      if (op_en) begin
         case (mode_e'(op_sel))
            MODE_SHL:   begin q_d = {q_q[N-2:0], si};       dir_d = 1'b0; end
            MODE_SHR:   begin q_d = {si, q_q[N-1:1]};       dir_d = 1'b1; end
            MODE_ROL:   begin q_d = {q_q[N-2:0], q_q[N-1]}; dir_d = 1'b0; end
            MODE_ROR:   begin q_d = {q_q[0], q_q[N-1:1]};   dir_d = 1'b1; end
            MODE_ASR:   begin q_d = {q_q[N-1], q_q[N-1:1]}; dir_d = 1'b1; end
            MODE_PLOAD: q_d = pdata;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         q_q   <= '0;
         dir_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         dir_q <= dir_d;
      end
   end

   assign q  = q_q;
   assign so = dir_q ? q_q[0] : q_q[N-1];

`ifdef SHREG_PARITY_EN
   assign par = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (N=4); expected values are queued
// when stimulus is driven and popped when the result is sampled.
module tb_univ_shift_reg;

   localparam int N = 4;
   localparam int CNT_W = $clog2(N + 1);

   logic             clk = 1'b0;
   logic             clear = 1'b1;
   logic             en = 1'b0;
   logic [2:0]       mode = 3'b000;
   logic             si = 1'b0;
   logic [N-1:0]     pdata = '0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic [N-1:0]     q;
   logic             so;
   logic             busy;
   logic             done;
`ifdef SHREG_PARITY_EN
   logic             par;
`endif

   int errors = 0;
   int checks = 0;

   logic [N-1:0] sb_q[$];
   logic         sb_so[$];
   logic         sb_par[$];

   localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_SHR = 3'b010,
                          M_ROL = 3'b011, M_ROR = 3'b100, M_PLOAD = 3'b101,
                          M_ASR = 3'b110, M_RSVD = 3'b111;

   univ_shift_reg #(.N(N)) dut (
      .clk   (clk),
      .clear (clear),
      .en    (en),
      .mode  (mode),
      .si    (si),
      .pdata (pdata),
      .start (start),
      .len   (len),
      .q     (q),
      .so    (so),
      .busy  (busy),
      .done  (done)
`ifdef SHREG_PARITY_EN
      ,
      .par   (par)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pload(input logic [N-1:0] v);
      en = 1'b1; mode = M_PLOAD; pdata = v;
      tick();
      en = 1'b0; mode = M_HOLD;
   endtask

   task automatic test_reset();
      logic [N+2:0] obs;
      #1;
      checks++;
      obs = {q, so, busy, done};
      if (obs !== '0) begin
         errors++; $display("FAIL reset_init: q/so/busy/done=%b expected 0", obs);
      end else $display("reset_init ok q=%b", q);
      @(negedge clk); clear = 1'b0;
      pload(4'hA);
      checks++;
      if (q !== 4'hA) begin
         errors++; $display("FAIL reset_pload: q=%h expected a", q);
      end else $display("reset_pload ok q=%h", q);
      #2 clear = 1'b1;
      #1;
      checks++;
      obs = {q, so, busy, done};
      if (obs !== '0) begin
         errors++; $display("FAIL reset_async: q/so/busy/done=%b expected 0", obs);
      end else $display("reset_async ok q=%b", q);
      clear = 1'b0;
      // reset must abort a running burst
      start = 1'b1; mode = M_SHL; len = 3'd4; si = 1'b1;
      tick();
      start = 1'b0; mode = M_HOLD;
      tick();
      #2 clear = 1'b1;
      #1;
      checks++;
      obs = {q, so, busy, done};
      if (obs !== '0) begin
         errors++; $display("FAIL reset_abort: q/so/busy/done=%b expected 0", obs);
      end else $display("reset_abort ok busy=%b", busy);
      clear = 1'b0;
   endtask

   task automatic test_shl();
      logic [N-1:0] exp_tab[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
      logic         si_tab[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [N-1:0] e;
      en = 1'b1; mode = M_SHL;
      for (int i = 0; i < 4; i++) begin
         si = si_tab[i];
         sb_q.push_back(exp_tab[i]);
         tick();
         e = sb_q.pop_front();
         checks++;
         if (q !== e) begin
            errors++; $display("FAIL shl_step%0d: q=%b expected %b", i, q, e);
         end else $display("shl step %0d si=%b q=%b", i, si, q);
      end
      checks++;
      if (so !== 1'b1) begin
         errors++; $display("FAIL shl_so: so=%b expected 1", so);
      end else $display("shl so=%b", so);
      mode = M_RSVD;
      tick();
      checks++;
      if (q !== 4'b1011) begin
         errors++; $display("FAIL rsvd_hold: q=%b expected 1011", q);
      end else $display("rsvd hold q=%b", q);
      en = 1'b0; mode = M_HOLD; si = 1'b0;
   endtask

   task automatic test_rotate();
      logic [N-1:0] rol_tab[4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};
      logic [N-1:0] e;
      pload(4'b1001);
      en = 1'b1; mode = M_ROR;
      tick();
      checks++;
      if (q !== 4'b1100 || so !== 1'b0) begin
         errors++; $display("FAIL ror: q=%b so=%b expected q=1100 so=0", q, so);
      end else $display("ror q=%b so=%b", q, so);
      mode = M_ROL;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(rol_tab[i]);
         tick();
         e = sb_q.pop_front();
         checks++;
         if (q !== e) begin
            errors++; $display("FAIL rol_step%0d: q=%b expected %b", i, q, e);
         end else $display("rol step %0d q=%b", i, q);
      end
      checks++;
      if (so !== 1'b1) begin
         errors++; $display("FAIL rol_so: so=%b expected 1", so);
      end else $display("rol so=%b", so);
      en = 1'b0; mode = M_HOLD;
   endtask

   task automatic test_burst();
      int  nb;
      logic e;
      pload(4'hA);
      start = 1'b1; mode = M_SHR; len = 3'd4; si = 1'b0;
      sb_so.push_back(1'b0); sb_so.push_back(1'b1);
      sb_so.push_back(1'b0); sb_so.push_back(1'b1);
      tick();
      start = 1'b0; mode = M_HOLD;
      nb = 0;
      while (busy === 1'b1 && nb < 20) begin
         checks++;
         if (sb_so.size() == 0) begin
            errors++; $display("FAIL burst_so%0d: so=%b with no value expected", nb, so);
         end else begin
            e = sb_so.pop_front();
            if (so !== e) begin
               errors++; $display("FAIL burst_so%0d: so=%b expected %b", nb, so, e);
            end else $display("burst cycle %0d so=%b q=%b", nb, so, q);
         end
         nb++;
         tick();
      end
      sb_so.delete();
      checks++;
      if (nb != 4) begin
         errors++; $display("FAIL burst_len: busy cycles=%0d expected 4", nb);
      end else $display("burst busy cycles=%0d", nb);
      checks++;
      if (done !== 1'b1 || q !== 4'b0000) begin
         errors++; $display("FAIL burst_done: done=%b q=%b expected done=1 q=0000", done, q);
      end else $display("burst done=%b q=%b", done, q);
      // start accepted in the done cycle
      start = 1'b1; mode = M_SHL; len = 3'd2; si = 1'b1;
      tick();
      start = 1'b0; mode = M_HOLD;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 4'b0000) begin
         errors++; $display("FAIL b2b_start: busy=%b done=%b q=%b expected 1 0 0000", busy, done, q);
      end else $display("b2b start busy=%b", busy);
      nb = 0;
      while (busy === 1'b1 && nb < 20) begin nb++; tick(); end
      checks++;
      if (nb != 2 || q !== 4'b0011 || done !== 1'b1) begin
         errors++; $display("FAIL b2b_end: cycles=%0d q=%b done=%b expected 2 0011 1", nb, q, done);
      end else $display("b2b cycles=%0d q=%b", nb, q);
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse: done=%b expected 0", done);
      end else $display("done pulse cleared");
      si = 1'b0;
   endtask

   task automatic test_burst_ignore();
      int nb;
      pload(4'b0110);
      start = 1'b1; mode = M_ROL; len = 3'd3;
      tick();
      start = 1'b1; en = 1'b1; mode = M_PLOAD; pdata = 4'hF; len = 3'd4;
      nb = 0;
      while (busy === 1'b1 && nb < 20) begin nb++; tick(); end
      start = 1'b0; en = 1'b0; mode = M_HOLD;
      checks++;
      if (nb != 3 || q !== 4'b0011) begin
         errors++; $display("FAIL burst_ignore: cycles=%0d q=%b expected 3 0011", nb, q);
      end else $display("burst ignore cycles=%0d q=%b", nb, q);
      // len=0 is not a burst
      start = 1'b1; mode = M_SHL; len = 3'd0;
      tick();
      start = 1'b0; mode = M_HOLD;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 4'b0011) begin
         errors++; $display("FAIL len_zero: busy=%b done=%b q=%b expected 0 0 0011", busy, done, q);
      end else $display("len zero ignored q=%b", q);
   endtask

   task automatic test_asr();
      logic [N-1:0] exp_tab[3] = '{4'b1100, 4'b1110, 4'b1111};
      logic         par_tab[3] = '{1'b0, 1'b1, 1'b0};
      logic [N-1:0] e;
      logic         ep;
      pload(4'b1000);
`ifdef SHREG_PARITY_EN
      checks++;
      if (par !== 1'b1) begin
         errors++; $display("FAIL par_load: par=%b expected 1", par);
      end else $display("par after load=%b", par);
`endif
      en = 1'b1; mode = M_ASR; si = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(exp_tab[i]);
         sb_par.push_back(par_tab[i]);
         tick();
         e  = sb_q.pop_front();
         ep = sb_par.pop_front();
         checks++;
         if (q !== e) begin
            errors++; $display("FAIL asr_step%0d: q=%b expected %b", i, q, e);
         end else $display("asr step %0d q=%b expected par=%b", i, q, ep);
`ifdef SHREG_PARITY_EN
         checks++;
         if (par !== ep) begin
            errors++; $display("FAIL asr_par%0d: par=%b expected %b", i, par, ep);
         end
`endif
      end
      en = 1'b0; mode = M_HOLD;
   endtask

   initial begin
      test_reset();
      test_shl();
      test_rotate();
      test_burst();
      test_burst_ignore();
      test_asr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised N-bit universal shift register and the successor to the fixed-mode SISO register. It supports hold, logical shift left/right, rotate left/right, arithmetic shift right and parallel load, with serial in/out and parallel out. A burst engine shifts automatically for a programmed count and signals busy/done. It is used as the serialiser/deserialiser front end for the serial peripherals.

Parameters:
N, 4, register width in bits; legal range N >= 2.
CNT_W, $clog2(N+1) derived localparam, width of the len input and the burst counter; the maximum burst is 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-high reset
en  input  1  manual enable; executes mode once per clock while IDLE
mode  input  3  op select: 000 HOLD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 PLOAD, 110 ASR, 111 HOLD (reserved)
si  input  1  serial in
pdata  input  N  parallel load data
start  input  1  burst request
len  input  CNT_W  burst length in clocks
q  output  N  register contents
so  output  1  serial out
busy  output  1  burst in progress
done  output  1  one-cycle burst-complete pulse

Behaviour:
- Reset (clear=1, async): q=0, dir=0, busy=0, done=0, state=IDLE, count=0. Therefore so=0. Reset takes effect without a clock edge and aborts any burst.
- Ops per executing edge:
  - SHL: q<={q[N-2:0],si}, dir<=0.
  - SHR: q<={si,q[N-1:1]}, dir<=1.
  - ROL: q<={q[N-2:0],q[N-1]}, dir<=0.
  - ROR: q<={q[0],q[N-1:1]}, dir<=1.
  - ASR: q<={q[N-1],q[N-1:1]}, dir<=1, si ignored.
  - PLOAD: q<=pdata, dir unchanged.
  - HOLD/111: no change.
- so = dir ? q[0] : q[N-1] (combinational from registers).
- FSM states: IDLE, RUN.
- IDLE, start=1, len!=0, mode in {SHL,SHR,ROL,ROR,ASR}:
  - latch mode into mode_q, count<=len, set dir per mode, state<=RUN.
  - No shift on the start edge.
  - start has priority over en.
- IDLE, start with len=0 or mode in {HOLD,PLOAD,111}: ignored as a burst. If en=1, the mode op executes normally.
- IDLE, en=1, no valid start: execute mode once.
- RUN: busy=1. Each edge executes mode_q with live si and decrements count. The edge where count==1 moves to IDLE and sets done=1 for exactly one cycle.
  - busy is high for exactly len cycles.
  - start, en, mode and pdata are ignored while in RUN.
- done cycle: state is already IDLE, so a start or en in that cycle is accepted.
- len > N is legal; shifting continues past the full width.

Optional Feature:
Macro SHREG_PARITY_EN.
- Defined: adds output port par (1 bit) = ^q, combinational from q; par=0 in reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package shreg_pkg: 3-bit mode enum (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_PLOAD, MODE_ASR, MODE_RSVD), FSM state enum (ST_IDLE, ST_RUN), and the helper function is_shift_mode().
- One natural sub-module: shreg_burst_ctrl. It holds the FSM, count, mode_q, busy and done, and outputs the effective op-enable and op-select to the datapath in the top.

Test Plan:
1. Load q=4'hA via PLOAD, then pulse clear between edges -> q=0, so=0, busy=0, done=0 immediately, without a clock edge.
2. N=4, en=1, mode=SHL, si=1,0,1,1 over 4 clocks -> q=0001, 0010, 0101, 1011; so=1 at end.
3. PLOAD 4'b1001, then ROR x1 -> q=1100, so=0. Then ROL x4 -> q=1100 (unchanged), so=1.
4. PLOAD 4'hA, then start with mode=SHR, len=4, si=0:
   - busy high exactly 4 cycles, so stream 0,1,0,1.
   - q=0000 at end.
   - done high for exactly the one cycle after busy falls.
5. Start a burst with len=3, and pulse start, en=1 mode=PLOAD mid-burst -> ignored, busy still exactly 3 cycles. Separately, start with len=0 -> busy and done stay 0.
6. PLOAD 4'b1000, ASR x3 with si=0 -> q=1100, 1110, 1111. With SHREG_PARITY_EN defined -> par=1, 0, 1, 0 after load and each step.
